snow64_multi_port_memory_bus_guard: RTL and testbench
=====================================================

Name: snow64_multi_port_memory_bus_guard

Overview:
- Parametrised successor to the fixed three-requester memory bus guard.
- Arbitrates NUM_PORTS independent requesters (instruction fetch, data load/store, future DMA, ...) onto one shared memory port.
- Fairness: round-robin. At most one memory transaction is outstanding at a time.
- Adds per-port pending-request latching, a mixed read/write request per port, and an optional memory-response timeout with an error flag.

Parameters:
- NUM_PORTS, 3, number of requester ports (2..8).
- ADDR_WIDTH, 64, CPU address width.
- DATA_WIDTH, 256, LAR data line width.
- TIMEOUT_CYCLES, 0, cycles to wait for mem valid before aborting; 0 disables the timeout.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_port_req  in  NUM_PORTS  per-port single-cycle request pulse.
- in_port_acc_type  in  NUM_PORTS  per-port access type: 0 read, 1 write.
- in_port_addr  in  NUM_PORTS*ADDR_WIDTH  per-port address; port i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- in_port_data  in  NUM_PORTS*DATA_WIDTH  per-port write data.
- out_port_valid  out  NUM_PORTS  per-port completion pulse.
- out_port_err  out  NUM_PORTS  completion was a timeout abort.
- out_port_data  out  DATA_WIDTH  read data for the completing port (shared bus).
- in_mem_valid  in  1  memory completion pulse.
- in_mem_data  in  DATA_WIDTH  memory read data.
- out_mem_req  out  1  memory request pulse.
- out_mem_acc_type  out  1  0 read, 1 write.
- out_mem_addr  out  ADDR_WIDTH  memory address.
- out_mem_data  out  DATA_WIDTH  memory write data.

Behaviour:
- Reset (rst high at an edge):
  - All outputs 0; pending[] cleared; state StIdle; timeout counter 0.
  - last_grant = NUM_PORTS-1, so port 0 has first priority.
  - Reset mid-transaction drops all work. A late in_mem_valid after reset is ignored.
- Latching: in_port_req[i]=1 with pending[i]=0 loads pending[i]=1 with that port's addr, data and acc_type.
  - in_port_req[i] while pending[i]=1 is ignored; the original request is kept.
- State StIdle, with any pending bit set:
  - Grant the first pending port scanning last_grant+1, last_grant+2, ..., wrapping modulo NUM_PORTS.
  - Registered outputs: out_mem_req=1 for exactly one cycle, carrying the granted port's addr/data/acc_type.
  - Move to StWaitForMem; cur_port=grant; last_grant=grant.
  - Minimum latency: request pulse in cycle t -> out_mem_req high in cycle t+2.
- StIdle, nothing pending: out_mem_req=0. An in_mem_valid arriving here is ignored.
- StWaitForMem:
  - out_mem_addr/data/acc_type hold their values; out_mem_req=0.
  - On in_mem_valid=1 in cycle v, in cycle v+1:
    - out_port_valid[cur_port]=1 (one cycle).
    - out_port_data = in_mem_data for reads, 0 for writes.
    - out_port_err=0.
    - pending[cur_port] is cleared at the edge ending cycle v; return to StIdle.
  - Next grant is issued no earlier than cycle v+2.
- Timeout (TIMEOUT_CYCLES>0):
  - The counter resets on entry to StWaitForMem and increments each cycle in that state.
  - When it reaches TIMEOUT_CYCLES without in_mem_valid: out_port_valid[cur_port]=1, out_port_err[cur_port]=1, out_port_data=0, pending cleared, StIdle.
  - If in_mem_valid and the timeout occur in the same cycle, in_mem_valid wins (normal completion, err=0).
- Re-request: a port's in_port_req in the same cycle its out_port_valid is high is accepted, because pending is already 0.
- Wrap-around: the round-robin pointer wraps from NUM_PORTS-1 to 0. A port requesting continuously is served at most once per NUM_PORTS grants while others are pending.
- Outputs: out_port_valid and out_port_err are all-zero except in completion cycles. At most one bit of out_port_valid is set per cycle.

Test Plan:
- Single read: port1 req, addr=0x1000, read; mem valid 3 cycles after out_mem_req with data=0xAB..AB -> out_mem_req in cycle t+2 with addr 0x1000; out_port_valid=3'b010 for one cycle; data 0xAB..AB; err=0.
- Simultaneous: ports 0, 1, 2 all req in the same cycle -> grants in order 0, 1, 2. Then port 0 re-requests while port 2 re-requests -> next grant is 0 (last_grant=2, wraps).
- Write: port2 write, addr=0x40, data=0x55..55 -> out_mem_acc_type=1, out_mem_data=0x55..55; completion with out_port_data=0.
- Duplicate req: port0 pulses req with addr 0x10, then again with addr 0x20 while pending -> exactly one mem request, with addr 0x10.
- Timeout: TIMEOUT_CYCLES=8, no mem valid -> out_port_valid and out_port_err for that port asserted once, 8 cycles after entering StWaitForMem. A late in_mem_valid afterwards produces no port response.
- Reset mid-op: assert rst during StWaitForMem with ports 1 and 2 pending -> all outputs 0. Later in_mem_valid is ignored. Next single port2 req is served normally.

Source files
------------

// File: rtl/snow64_multi_port_memory_bus_guard.sv
// Round-robin guard that funnels NUM_PORTS requesters onto one shared memory port.
// Each port latches one pending request (read or write). Only one memory transaction
// is in flight at a time. An optional response timeout completes the transaction
// with an error flag.
module snow64_multi_port_memory_bus_guard #(
  parameter int unsigned NUM_PORTS      = 3,
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned DATA_WIDTH     = 256,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             in_port_req,
  input  logic [NUM_PORTS-1:0]             in_port_acc_type,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  in_port_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  in_port_data,
  output logic [NUM_PORTS-1:0]             out_port_valid,
  output logic [NUM_PORTS-1:0]             out_port_err,
  output logic [DATA_WIDTH-1:0]            out_port_data,
  input  logic                             in_mem_valid,
  input  logic [DATA_WIDTH-1:0]            in_mem_data,
  output logic                             out_mem_req,
  output logic                             out_mem_acc_type,
  output logic [ADDR_WIDTH-1:0]            out_mem_addr,
  output logic [DATA_WIDTH-1:0]            out_mem_data
);

  localparam int unsigned PortW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  // One extra bit so last_grant + offset never overflows before the wrap.
  localparam int unsigned CandW = PortW + 1;
  localparam int unsigned CntW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Counter value in the last cycle before the timeout fires.
  localparam logic [CntW-1:0] TmoLast =
      CntW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [0:0] {StIdle, StWaitForMem} state_e;

  state_e                                state_q;
  logic [NUM_PORTS-1:0]                  pending_q;
  logic [NUM_PORTS-1:0]                  port_acc_q;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  port_addr_q;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  port_data_q;
  logic [PortW-1:0]                      cur_port_q;
  logic [PortW-1:0]                      last_grant_q;
  logic [CntW-1:0]                       tmo_cnt_q;

  logic [NUM_PORTS-1:0]                  accept;
  logic                                  grant_valid;
  logic [PortW-1:0]                      grant_idx;
  logic                                  tmo_hit;

  // A request is only taken when the port has no pending work; repeats are dropped.
  assign accept  = in_port_req & ~pending_q;
  assign tmo_hit = (TIMEOUT_CYCLES > 0) && (tmo_cnt_q == TmoLast);

  // Round-robin pick: first pending port after last_grant, wrapping modulo NUM_PORTS.
  always_comb begin
    logic [CandW-1:0] cand;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      cand = {1'b0, last_grant_q} + CandW'(k);
      if (cand >= CandW'(NUM_PORTS)) begin
        cand = cand - CandW'(NUM_PORTS);
      end
      if (!grant_valid && pending_q[cand[PortW-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[PortW-1:0];
      end
    end
  end

  // Capture each accepted request's payload so the port may change its inputs freely.
  always_ff @(posedge clk) begin
    if (rst) begin
      port_acc_q  <= '0;
      port_addr_q <= '0;
      port_data_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        if (accept[i]) begin
          port_acc_q[i]  <= in_port_acc_type[i];
          port_addr_q[i] <= in_port_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
          port_data_q[i] <= in_port_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Arbitration FSM with registered memory-side and port-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= StIdle;
      pending_q        <= '0;
      cur_port_q       <= '0;
      last_grant_q     <= PortW'(NUM_PORTS - 1);
      tmo_cnt_q        <= '0;
      out_port_valid   <= '0;
      out_port_err     <= '0;
      out_port_data    <= '0;
      out_mem_req      <= 1'b0;
      out_mem_acc_type <= 1'b0;
      out_mem_addr     <= '0;
      out_mem_data     <= '0;
    end else begin
      // Pulse outputs default low; the memory address/data/type hold their last value.
      out_mem_req    <= 1'b0;
      out_port_valid <= '0;
      out_port_err   <= '0;
      out_port_data  <= '0;
      pending_q      <= pending_q | accept;

      unique case (state_q)
        StIdle: begin
          if (grant_valid) begin
            out_mem_req      <= 1'b1;
            out_mem_acc_type <= port_acc_q[grant_idx];
            out_mem_addr     <= port_addr_q[grant_idx];
            out_mem_data     <= port_data_q[grant_idx];
            cur_port_q       <= grant_idx;
            last_grant_q     <= grant_idx;
            tmo_cnt_q        <= '0;
            state_q          <= StWaitForMem;
          end
        end
        StWaitForMem: begin
          // A memory response takes priority over a timeout in the same cycle.
          if (in_mem_valid) begin
            out_port_valid[cur_port_q] <= 1'b1;
            out_port_data              <= port_acc_q[cur_port_q] ? '0 : in_mem_data;
            pending_q[cur_port_q]      <= 1'b0;
            state_q                    <= StIdle;
          end else if (tmo_hit) begin
            out_port_valid[cur_port_q] <= 1'b1;
            out_port_err[cur_port_q]   <= 1'b1;
            pending_q[cur_port_q]      <= 1'b0;
            state_q                    <= StIdle;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snow64_multi_port_memory_bus_guard.sv
// Self-checking bench for snow64_multi_port_memory_bus_guard (3 ports, timeout of 8).
// Expected memory requests and port completions are queued when stimulus is driven
// and compared as the guard produces them.
module tb_snow64_multi_port_memory_bus_guard;

  localparam int unsigned NP  = 3;
  localparam int unsigned AW  = 64;
  localparam int unsigned DW  = 256;
  localparam int unsigned TMO = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic [NP-1:0]      in_port_req;
  logic [NP-1:0]      in_port_acc_type;
  logic [NP*AW-1:0]   in_port_addr;
  logic [NP*DW-1:0]   in_port_data;
  logic [NP-1:0]      out_port_valid;
  logic [NP-1:0]      out_port_err;
  logic [DW-1:0]      out_port_data;
  logic               in_mem_valid;
  logic [DW-1:0]      in_mem_data;
  logic               out_mem_req;
  logic               out_mem_acc_type;
  logic [AW-1:0]      out_mem_addr;
  logic [DW-1:0]      out_mem_data;

  always #5 clk = ~clk;

  snow64_multi_port_memory_bus_guard #(
    .NUM_PORTS     (NP),
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .in_port_req     (in_port_req),
    .in_port_acc_type(in_port_acc_type),
    .in_port_addr    (in_port_addr),
    .in_port_data    (in_port_data),
    .out_port_valid  (out_port_valid),
    .out_port_err    (out_port_err),
    .out_port_data   (out_port_data),
    .in_mem_valid    (in_mem_valid),
    .in_mem_data     (in_mem_data),
    .out_mem_req     (out_mem_req),
    .out_mem_acc_type(out_mem_acc_type),
    .out_mem_addr    (out_mem_addr),
    .out_mem_data    (out_mem_data)
  );

  typedef struct {
    int            port;
    logic          acc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } mem_exp_t;

  typedef struct {
    logic [NP-1:0] valid;
    logic [NP-1:0] err;
    logic [DW-1:0] data;
  } port_exp_t;

  mem_exp_t  mem_q[$];
  port_exp_t port_q[$];
  int        n_checks = 0;
  int        n_pass   = 0;

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    mem_q.delete();
    port_q.delete();
  endtask

  task automatic set_port(input int p, input logic acc, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    in_port_req[p]            = 1'b1;
    in_port_acc_type[p]       = acc;
    in_port_addr[p*AW +: AW]  = a;
    in_port_data[p*DW +: DW]  = d;
  endtask

  task automatic exp_mem(input int p, input logic acc, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    mem_exp_t e;
    e.port = p;
    e.acc  = acc;
    e.addr = a;
    e.data = d;
    mem_q.push_back(e);
  endtask

  // Queue the port-side completion implied by a memory response to request e.
  task automatic exp_done(input mem_exp_t e, input logic [DW-1:0] rdata, input logic err);
    port_exp_t pe;
    pe.valid = 3'b001 << e.port;
    pe.err   = err ? pe.valid : 3'b000;
    pe.data  = (e.acc || err) ? '0 : rdata;
    port_q.push_back(pe);
  endtask

  // Step until out_mem_req is seen in the current cycle, within a cycle budget.
  task automatic wait_mem_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (out_mem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // From the out_mem_req cycle, pulse in_mem_valid 'delay' cycles later; return in the
  // cycle where the port completion is due.
  task automatic mem_respond(input int delay, input logic [DW-1:0] d);
    for (int i = 0; i < delay; i++) tick();
    in_mem_valid = 1'b1;
    in_mem_data  = d;
    tick();
    in_mem_valid = 1'b0;
    in_mem_data  = '0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (out_mem_req === 1'b0 && out_mem_acc_type === 1'b0 && out_mem_addr === '0 &&
        out_mem_data === '0 && out_port_valid === '0 && out_port_err === '0 &&
        out_port_data === '0) n_pass++;
    else $display("FAIL reset_outputs: req=%b acc=%b addr=%h pv=%b perr=%b, required all 0",
                  out_mem_req, out_mem_acc_type, out_mem_addr, out_port_valid, out_port_err);
    // A memory response while idle must not reach any port.
    in_mem_valid = 1'b1;
    in_mem_data  = {32{8'hEE}};
    tick();
    in_mem_valid = 1'b0;
    tick();
    n_checks++;
    if (out_port_valid === '0 && out_mem_req === 1'b0) n_pass++;
    else $display("FAIL idle_mem_valid: pv=%b req=%b, required pv=000 req=0",
                  out_port_valid, out_mem_req);
  endtask

  task automatic test_single_read();
    mem_exp_t  e;
    port_exp_t pe;
    logic [DW-1:0] rd;
    do_reset();
    rd = {32{8'hAB}};
    set_port(1, 1'b0, 64'h1000, {32{8'h11}});
    exp_mem(1, 1'b0, 64'h1000, {32{8'h11}});
    tick();
    in_port_req = '0;
    n_checks++;
    if (out_mem_req === 1'b0) n_pass++;
    else $display("FAIL single_t1: out_mem_req=%b, required 0", out_mem_req);
    tick();
    e = mem_q.pop_front();
    n_checks++;
    if (out_mem_req === 1'b1 && out_mem_addr === e.addr && out_mem_acc_type === e.acc &&
        out_mem_data === e.data) n_pass++;
    else $display("FAIL single_t2_req: req=%b addr=%h acc=%b, required req=1 addr=%h acc=%b",
                  out_mem_req, out_mem_addr, out_mem_acc_type, e.addr, e.acc);
    exp_done(e, rd, 1'b0);
    mem_respond(3, rd);
    pe = port_q.pop_front();
    n_checks++;
    if (out_port_valid === pe.valid && out_port_err === pe.err && out_port_data === pe.data)
      n_pass++;
    else $display("FAIL single_done: pv=%b err=%b data=%h, required pv=%b err=%b data=%h",
                  out_port_valid, out_port_err, out_port_data, pe.valid, pe.err, pe.data);
    tick();
    n_checks++;
    if (out_port_valid === '0 && out_mem_req === 1'b0) n_pass++;
    else $display("FAIL single_pulse: pv=%b req=%b, required pv=000 req=0",
                  out_port_valid, out_mem_req);
  endtask

  // Ports 0..2 together, then re-requests in completion cycles to exercise wrap-around.
  task automatic test_simultaneous();
    mem_exp_t  e;
    port_exp_t pe;
    bit        ok;
    logic [7:0]    b;
    logic [DW-1:0] rd;
    do_reset();
    for (int p = 0; p < 3; p++) begin
      set_port(p, 1'b0, AW'((p + 1) * 'h100), {32{8'(8'h30 + p)}});
      exp_mem(p, 1'b0, AW'((p + 1) * 'h100), {32{8'(8'h30 + p)}});
    end
    tick();
    in_port_req = '0;
    for (int k = 0; k < 6; k++) begin
      wait_mem_req(ok);
      e = mem_q.pop_front();
      n_checks++;
      if (ok && out_mem_addr === e.addr && out_mem_acc_type === e.acc &&
          out_mem_data === e.data) n_pass++;
      else $display("FAIL rr_grant%0d: seen=%0d addr=%h, required addr=%h (port %0d)",
                    k, ok, out_mem_addr, e.addr, e.port);
      b  = 8'h50 + 8'(k);
      rd = {32{b}};
      exp_done(e, rd, 1'b0);
      mem_respond(1, rd);
      pe = port_q.pop_front();
      n_checks++;
      if (out_port_valid === pe.valid && out_port_err === pe.err && out_port_data === pe.data)
        n_pass++;
      else $display("FAIL rr_done%0d: pv=%b err=%b data=%h, required pv=%b err=%b data=%h",
                    k, out_port_valid, out_port_err, out_port_data, pe.valid, pe.err, pe.data);
      if (k == 2) begin
        // Ports 0 and 2 re-request as port 2 completes; last grant was 2 so 0 wins.
        set_port(0, 1'b0, 64'h400, '0);
        set_port(2, 1'b0, 64'h600, '0);
        exp_mem(0, 1'b0, 64'h400, '0);
        exp_mem(2, 1'b0, 64'h600, '0);
        tick();
        in_port_req = '0;
      end else if (k == 3) begin
        // Port 0 re-requests while port 2 is still pending; port 2 goes first.
        set_port(0, 1'b0, 64'h500, '0);
        exp_mem(2, 1'b0, 64'h600, '0);
        exp_mem(0, 1'b0, 64'h500, '0);
        void'(mem_q.pop_front());
        tick();
        in_port_req = '0;
      end
    end
  endtask

  task automatic test_write();
    mem_exp_t  e;
    port_exp_t pe;
    bit        ok;
    do_reset();
    set_port(2, 1'b1, 64'h40, {32{8'h55}});
    exp_mem(2, 1'b1, 64'h40, {32{8'h55}});
    tick();
    in_port_req = '0;
    wait_mem_req(ok);
    e = mem_q.pop_front();
    n_checks++;
    if (ok && out_mem_acc_type === 1'b1 && out_mem_addr === e.addr && out_mem_data === e.data)
      n_pass++;
    else $display("FAIL write_req: seen=%0d acc=%b addr=%h data=%h, required acc=1 addr=%h data=%h",
                  ok, out_mem_acc_type, out_mem_addr, out_mem_data, e.addr, e.data);
    exp_done(e, {32{8'hC3}}, 1'b0);
    mem_respond(2, {32{8'hC3}});
    pe = port_q.pop_front();
    n_checks++;
    if (out_port_valid === pe.valid && out_port_err === pe.err && out_port_data === pe.data)
      n_pass++;
    else $display("FAIL write_done: pv=%b err=%b data=%h, required pv=%b err=%b data=%h",
                  out_port_valid, out_port_err, out_port_data, pe.valid, pe.err, pe.data);
  endtask

  task automatic test_duplicate();
    mem_exp_t  e;
    port_exp_t pe;
    bit        ok;
    bit        extra;
    do_reset();
    set_port(0, 1'b0, 64'h10, '0);
    exp_mem(0, 1'b0, 64'h10, '0);
    tick();
    set_port(0, 1'b0, 64'h20, {32{8'h77}});
    tick();
    in_port_req = '0;
    wait_mem_req(ok);
    e = mem_q.pop_front();
    n_checks++;
    if (ok && out_mem_addr === e.addr && out_mem_data === e.data) n_pass++;
    else $display("FAIL dup_req: seen=%0d addr=%h, required addr=%h", ok, out_mem_addr, e.addr);
    exp_done(e, {32{8'h99}}, 1'b0);
    mem_respond(2, {32{8'h99}});
    pe = port_q.pop_front();
    n_checks++;
    if (out_port_valid === pe.valid && out_port_data === pe.data) n_pass++;
    else $display("FAIL dup_done: pv=%b data=%h, required pv=%b data=%h",
                  out_port_valid, out_port_data, pe.valid, pe.data);
    extra = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_mem_req !== 1'b0) extra = 1'b1;
    end
    n_checks++;
    if (!extra) n_pass++;
    else $display("FAIL dup_single: extra out_mem_req seen=1, required 0");
  endtask

  task automatic test_timeout();
    mem_exp_t  e;
    port_exp_t pe;
    bit        ok;
    bit        early;
    bit        late;
    do_reset();
    set_port(1, 1'b0, 64'h3000, '0);
    exp_mem(1, 1'b0, 64'h3000, '0);
    tick();
    in_port_req = '0;
    wait_mem_req(ok);
    e = mem_q.pop_front();
    n_checks++;
    if (ok && out_mem_addr === e.addr) n_pass++;
    else $display("FAIL tmo_req: seen=%0d addr=%h, required addr=%h", ok, out_mem_addr, e.addr);
    exp_done(e, '0, 1'b1);
    early = 1'b0;
    for (int i = 1; i < TMO; i++) begin
      tick();
      if (out_port_valid !== '0) early = 1'b1;
    end
    n_checks++;
    if (!early) n_pass++;
    else $display("FAIL tmo_early: completion before %0d cycles seen=1, required 0", TMO);
    tick();
    pe = port_q.pop_front();
    n_checks++;
    if (out_port_valid === pe.valid && out_port_err === pe.err && out_port_data === pe.data)
      n_pass++;
    else $display("FAIL tmo_done: pv=%b err=%b data=%h, required pv=%b err=%b data=%h",
                  out_port_valid, out_port_err, out_port_data, pe.valid, pe.err, pe.data);
    in_mem_valid = 1'b1;
    in_mem_data  = {32{8'h5A}};
    tick();
    in_mem_valid = 1'b0;
    late = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (out_port_valid !== '0 || out_port_err !== '0) late = 1'b1;
    end
    n_checks++;
    if (!late) n_pass++;
    else $display("FAIL tmo_late_valid: port response seen=1, required 0");
    // Response in the very cycle the timeout would fire: normal completion.
    set_port(0, 1'b0, 64'h3100, '0);
    exp_mem(0, 1'b0, 64'h3100, '0);
    tick();
    in_port_req = '0;
    wait_mem_req(ok);
    e = mem_q.pop_front();
    exp_done(e, {32{8'h6C}}, 1'b0);
    mem_respond(TMO - 1, {32{8'h6C}});
    pe = port_q.pop_front();
    n_checks++;
    if (ok && out_port_valid === pe.valid && out_port_err === pe.err &&
        out_port_data === pe.data) n_pass++;
    else $display("FAIL tmo_tie: pv=%b err=%b data=%h, required pv=%b err=%b data=%h",
                  out_port_valid, out_port_err, out_port_data, pe.valid, pe.err, pe.data);
  endtask

  task automatic test_reset_midop();
    mem_exp_t  e;
    port_exp_t pe;
    bit        ok;
    bit        stray;
    do_reset();
    set_port(1, 1'b0, 64'h1111, '0);
    set_port(2, 1'b0, 64'h2222, '0);
    exp_mem(1, 1'b0, 64'h1111, '0);
    tick();
    in_port_req = '0;
    wait_mem_req(ok);
    e = mem_q.pop_front();
    n_checks++;
    if (ok && out_mem_addr === e.addr) n_pass++;
    else $display("FAIL midop_req: seen=%0d addr=%h, required addr=%h", ok, out_mem_addr, e.addr);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (out_mem_req === 1'b0 && out_mem_addr === '0 && out_mem_data === '0 &&
        out_mem_acc_type === 1'b0 && out_port_valid === '0 && out_port_err === '0 &&
        out_port_data === '0) n_pass++;
    else $display("FAIL midop_reset: req=%b addr=%h pv=%b, required all 0",
                  out_mem_req, out_mem_addr, out_port_valid);
    in_mem_valid = 1'b1;
    in_mem_data  = {32{8'hF0}};
    tick();
    in_mem_valid = 1'b0;
    stray = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (out_port_valid !== '0 || out_mem_req !== 1'b0) stray = 1'b1;
    end
    n_checks++;
    if (!stray) n_pass++;
    else $display("FAIL midop_stray: activity after reset seen=1, required 0");
    set_port(2, 1'b0, 64'h2345, {32{8'h12}});
    exp_mem(2, 1'b0, 64'h2345, {32{8'h12}});
    tick();
    in_port_req = '0;
    tick();
    e = mem_q.pop_front();
    n_checks++;
    if (out_mem_req === 1'b1 && out_mem_addr === e.addr && out_mem_data === e.data) n_pass++;
    else $display("FAIL midop_next_req: req=%b addr=%h, required req=1 addr=%h",
                  out_mem_req, out_mem_addr, e.addr);
    exp_done(e, {32{8'h3C}}, 1'b0);
    mem_respond(1, {32{8'h3C}});
    pe = port_q.pop_front();
    n_checks++;
    if (out_port_valid === pe.valid && out_port_err === pe.err && out_port_data === pe.data)
      n_pass++;
    else $display("FAIL midop_next_done: pv=%b data=%h, required pv=%b data=%h",
                  out_port_valid, out_port_data, pe.valid, pe.data);
  endtask

  initial begin
    rst              = 1'b0;
    in_port_req      = '0;
    in_port_acc_type = '0;
    in_port_addr     = '0;
    in_port_data     = '0;
    in_mem_valid     = 1'b0;
    in_mem_data      = '0;
    #2;
    test_reset();
    test_single_read();
    test_simultaneous();
    test_write();
    test_duplicate();
    test_timeout();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached with %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
